bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, two-slave shared-bus controller for the 8-bit system bus. It arbitrates bus ownership between master 0 (host/test master) and master 1 (the timer's load-fetch master port), and multiplexes the granted master's address, write strobe and write data onto the shared bus. It decodes the address into slave selects for the timer register file and the FIFO/memory slave, and returns the selected slave's read data to both masters. Fairness is round-robin, and a hold limit prevents either master from starving the other.

## Interface
- MAX_HOLD, 16: maximum consecutive granted cycles while the other master is requesting; valid range 2..255.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- M0_req  in  1  master 0 bus request; held high for the whole transfer sequence.
- M0_address  in  8  master 0 address.
- M0_wr  in  1  master 0 write strobe (1 = write, 0 = read).
- M0_dout  in  8  master 0 write data.
- M1_req, M1_address, M1_wr, M1_dout  in  1/8/1/8  master 1 counterparts.
- S0_dout  in  8  timer register slave read data.
- S1_dout  in  8  FIFO/memory slave read data.
- M0_grant  out  1  master 0 owns the bus.
- M1_grant  out  1  master 1 owns the bus.
- S_address  out  8  shared bus address.
- S_wr  out  1  shared bus write strobe.
- S_din  out  8  shared bus write data.
- S0_sel  out  1  selects the timer register slave.
- S1_sel  out  1  selects the FIFO/memory slave.
- M_din  out  8  read data returned to both masters.

## Operation
- State machine states: IDLE, GNT0, GNT1. Grants are registered: M0_grant = (state == GNT0) and M1_grant = (state == GNT1).
- Round-robin pointer `last` records the most recently granted master. Reset value 1, so master 0 wins the first tie.
- From IDLE:
  - Only one master requesting: grant that master.
  - Both requesting: grant the master not equal to `last`.
  - Neither requesting: stay in IDLE.
- From GNTx:
  - Requester x drops its request: if the other master is requesting, go directly to GNTother; otherwise go to IDLE.
  - hold_cnt reaches MAX_HOLD-1 while the other master is requesting: forced handover to GNTother, even if x is still requesting.
  - hold_cnt counts granted cycles. It clears on every grant change and saturates at MAX_HOLD-1.
- Bus mux (combinational from state):
  - GNT0: S_address, S_wr, S_din come from the M0 signals.
  - GNT1: S_address, S_wr, S_din come from the M1 signals.
  - IDLE: S_address = 0, S_wr = 0, S_din = 0.
- Address decode, gated by any grant:
  - S_address[7:5] = 3'b000 (0x00–0x1F): S0_sel = 1.
  - S_address[7:5] = 3'b001 (0x20–0x3F): S1_sel = 1.
  - All other addresses: no select, and M_din = 0x00.
- M_din = selected slave dout; 0x00 when no slave is selected or in IDLE.
- A granted master must not assume bus ownership once its grant falls. A write issued in the cycle the grant drops is not performed.

## Timing
- Reset values: state = IDLE, last = 1, hold_cnt = 0. All outputs are 0.
- Request to grant latency: 1 cycle. A request sampled at edge n gives grant high after edge n.
- Handover GNT0 to GNT1 takes no IDLE bubble; the two grants are never high in the same cycle.
- Release to IDLE: the grant falls 1 cycle after the request falls.
- Bus signals and selects follow the grant combinationally, so the first transfer happens in the first granted cycle.
- Read data path: M_din is combinational from S0_dout/S1_dout. Any extra read latency belongs to the slave.
- Forced handover: the holder keeps the bus for exactly MAX_HOLD cycles when the other master is contending.
- Reset asserted mid-transfer: the next edge returns the block to the reset values and drops the grant immediately.
- Both requests rising in the same cycle after reset: master 0 is granted first.

## Structure
- Shared package bus_pkg:
  - arb_state_t enum {IDLE, GNT0, GNT1}.
  - Slave address region constants SLV0_BASE = 3'b000 and SLV1_BASE = 3'b001.
  - Default read value 8'h00.
- One sub-module, bus_addr_decoder: combinational S_address decode producing S0_sel, S1_sel and the M_din mux. The arbiter FSM, the `last` pointer and hold_cnt stay in bus_arbiter.

## Test plan
- Reset release, M0_req = 1 only, M0_address = 0x05, M0_wr = 1, M0_dout = 0xA5 → M0_grant high 1 cycle later; S0_sel = 1; S_din = 0xA5.
- M0_req and M1_req both rising the cycle after reset → GNT0 first; when M0 drops, GNT1 next cycle with no IDLE cycle in between.
- M1 holds its request continuously with M0 also requesting, MAX_HOLD = 4 → M1_grant is high exactly 4 cycles, then M0_grant.
- M1 reads address 0x20 while S1_dout = 0x3C → S1_sel = 1 and M_din = 0x3C. Same read at address 0x80 → no select, M_din = 0x00.
- Reset asserted while GNT1 is active → the next cycle has all outputs 0 and state IDLE. A following simultaneous request grants M0.
- Alternating simultaneous requests, each holding for 2 cycles → grant order M0, M1, M0, M1; neither grant is ever high together with the other.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types and constants for the 8-bit system bus
//                arbiter and its address decoder.
//                - arb_state_t   : arbiter FSM states (IDLE, GNT0, GNT1)
//                - SLV0_BASE     : address region [7:5] of the timer registers
//                - SLV1_BASE     : address region [7:5] of the FIFO/memory slave
//                - DEFAULT_RDATA : read data returned when nothing is selected
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] SLV0_BASE     = 3'b000;
    localparam logic [2:0] SLV1_BASE     = 3'b001;
    localparam logic [7:0] DEFAULT_RDATA = 8'h00;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_addr_decoder
//  Description : Combinational slave decode and read-data return mux.
//                Ports:
//                  bus_active_i  - some master currently owns the bus
//                  addr_region_i - shared bus address bits [7:5]
//                  s0_dout_i     - timer register slave read data
//                  s1_dout_i     - FIFO/memory slave read data
//                  s0_sel_o      - timer register slave select
//                  s1_sel_o      - FIFO/memory slave select
//                  m_din_o       - read data returned to the masters
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decoder
    import bus_pkg::*;
(
    input  logic       bus_active_i,
    input  logic [2:0] addr_region_i,
    input  logic [7:0] s0_dout_i,
    input  logic [7:0] s1_dout_i,
    output logic       s0_sel_o,
    output logic       s1_sel_o,
    output logic [7:0] m_din_o
);

    always_comb begin
        s0_sel_o = bus_active_i && (addr_region_i == SLV0_BASE);
        s1_sel_o = bus_active_i && (addr_region_i == SLV1_BASE);
        m_din_o  = DEFAULT_RDATA;
        if (s0_sel_o) begin
            m_din_o = s0_dout_i;
        end else if (s1_sel_o) begin
            m_din_o = s1_dout_i;
        end
    end

endmodule : bus_addr_decoder
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master / two-slave shared bus controller. Round-robin
//                arbitration with a hold limit, bus mux of the granted master
//                and slave decode with read-data return.
//                Ports:
//                  clk, reset               - clock, sync active-high reset
//                  M0_req/address/wr/dout   - master 0 request and bus signals
//                  M1_req/address/wr/dout   - master 1 request and bus signals
//                  S0_dout, S1_dout         - slave read data
//                  M0_grant, M1_grant       - registered bus grants
//                  S_address, S_wr, S_din   - shared bus (granted master)
//                  S0_sel, S1_sel           - slave selects
//                  M_din                    - read data to both masters
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       M0_req,
    input  logic [7:0] M0_address,
    input  logic       M0_wr,
    input  logic [7:0] M0_dout,
    input  logic       M1_req,
    input  logic [7:0] M1_address,
    input  logic       M1_wr,
    input  logic [7:0] M1_dout,
    input  logic [7:0] S0_dout,
    input  logic [7:0] S1_dout,
    output logic       M0_grant,
    output logic       M1_grant,
    output logic [7:0] S_address,
    output logic       S_wr,
    output logic [7:0] S_din,
    output logic       S0_sel,
    output logic       S1_sel,
    output logic [7:0] M_din
);

    // Last cycle of an allowed tenure while the other master contends.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t state_q, state_d;
    logic       last_q,  last_d;
    logic [7:0] hold_q,  hold_d;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (M0_req && M1_req) begin
                    // Tie goes to whoever was not granted most recently.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (M0_req) begin
                    state_d = GNT0;
                end else if (M1_req) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!M0_req) begin
                    state_d = M1_req ? GNT1 : IDLE;
                end else if (M1_req && (hold_q == HOLD_LAST)) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (!M1_req) begin
                    state_d = M0_req ? GNT0 : IDLE;
                end else if (M0_req && (hold_q == HOLD_LAST)) begin
                    state_d = GNT0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    // hold counter: number of cycles already spent in the current grant,
    // restarting at zero on each grant change and saturating at HOLD_LAST.
    always_comb begin
        hold_d = hold_q;
        if ((state_d != state_q) || (state_q == IDLE)) begin
            hold_d = 8'd0;
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Grants and bus mux, purely from the registered state so a master
    // loses the bus in the same cycle its grant falls.
    // ------------------------------------------------------------------
    always_comb begin
        M0_grant  = (state_q == GNT0);
        M1_grant  = (state_q == GNT1);
        S_address = 8'h00;
        S_wr      = 1'b0;
        S_din     = 8'h00;
        if (M0_grant) begin
            S_address = M0_address;
            S_wr      = M0_wr;
            S_din     = M0_dout;
        end else if (M1_grant) begin
            S_address = M1_address;
            S_wr      = M1_wr;
            S_din     = M1_dout;
        end
    end

    bus_addr_decoder u_decoder (
        .bus_active_i  (M0_grant || M1_grant),
        .addr_region_i (S_address[7:5]),
        .s0_dout_i     (S0_dout),
        .s1_dout_i     (S1_dout),
        .s0_sel_o      (S0_sel),
        .s1_sel_o      (S1_sel),
        .m_din_o       (M_din)
    );

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed scoreboard bench for bus_arbiter (MAX_HOLD = 4).
//                The driver pushes the expected outputs of each cycle into a
//                queue; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] din;
        logic       s0;
        logic       s1;
        logic [7:0] mdin;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0] M0_address, M0_dout, M1_address, M1_dout;
    logic [7:0] S0_dout, S1_dout;
    logic       M0_grant, M1_grant, S_wr, S0_sel, S1_sel;
    logic [7:0] S_address, S_din, M_din;

    int    total = 0;
    int    bad   = 0;
    int    cyc_cnt = 0;
    item_t sb_q[$];

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M0_address (M0_address),
        .M0_wr      (M0_wr),
        .M0_dout    (M0_dout),
        .M1_req     (M1_req),
        .M1_address (M1_address),
        .M1_wr      (M1_wr),
        .M1_dout    (M1_dout),
        .S0_dout    (S0_dout),
        .S1_dout    (S1_dout),
        .M0_grant   (M0_grant),
        .M1_grant   (M1_grant),
        .S_address  (S_address),
        .S_wr       (S_wr),
        .S_din      (S_din),
        .S0_sel     (S0_sel),
        .S1_sel     (S1_sel),
        .M_din      (M_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Expected bus/decode outputs for a given expected grant pair.
    function automatic obs_t model(input logic eg0, input logic eg1);
        obs_t o;
        o.g0   = eg0;
        o.g1   = eg1;
        o.addr = eg0 ? M0_address : (eg1 ? M1_address : 8'h00);
        o.wr   = eg0 ? M0_wr      : (eg1 ? M1_wr      : 1'b0);
        o.din  = eg0 ? M0_dout    : (eg1 ? M1_dout    : 8'h00);
        o.s0   = (eg0 || eg1) && (o.addr <= 8'h1F);
        o.s1   = (eg0 || eg1) && (o.addr >= 8'h20) && (o.addr <= 8'h3F);
        o.mdin = o.s0 ? S0_dout : (o.s1 ? S1_dout : 8'h00);
        return o;
    endfunction

    // Record what this cycle must show, then advance one clock.
    task automatic cyc(input logic eg0, input logic eg1);
        item_t it;
        it.cyc = cyc_cnt;
        it.exp = model(eg0, eg1);
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare scoreboard entries due this cycle, and mutual exclusion.
    always @(negedge clk) begin
        obs_t  act;
        item_t it;
        act = '{M0_grant, M1_grant, S_address, S_wr, S_din, S0_sel, S1_sel, M_din};
        total = total + 1;
        if (M0_grant && M1_grant) begin
            bad = bad + 1;
            $display("FAIL grant_excl cyc=%0d both grants high", cyc_cnt);
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            it = sb_q.pop_front();
            total = total + 1;
            if (it.cyc != cyc_cnt || act !== it.exp) begin
                bad = bad + 1;
                $display("FAIL outputs cyc=%0d actual={g0=%b g1=%b a=%h wr=%b d=%h s0=%b s1=%b md=%h} required={g0=%b g1=%b a=%h wr=%b d=%h s0=%b s1=%b md=%h}",
                         it.cyc, act.g0, act.g1, act.addr, act.wr, act.din, act.s0, act.s1, act.mdin,
                         it.exp.g0, it.exp.g1, it.exp.addr, it.exp.wr, it.exp.din, it.exp.s0, it.exp.s1, it.exp.mdin);
            end
        end
    end

    initial begin
        reset = 1'b1;
        M0_req = 1'b0; M0_address = 8'h00; M0_wr = 1'b0; M0_dout = 8'h00;
        M1_req = 1'b0; M1_address = 8'h00; M1_wr = 1'b0; M1_dout = 8'h00;
        S0_dout = 8'h11; S1_dout = 8'h3C;
        @(posedge clk); #1;
        cyc(0, 0);                               // reset state

        // Single M0 write to the timer slave
        reset = 1'b0;
        M0_req = 1'b1; M0_address = 8'h05; M0_wr = 1'b1; M0_dout = 8'hA5;
        cyc(0, 0);                               // request seen at next edge
        cyc(1, 0);                               // S0_sel, S_din = A5
        M0_req = 1'b0;
        cyc(1, 0);                               // grant falls one cycle later
        cyc(0, 0);

        // Simultaneous requests right after reset, then hold-limit handovers
        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;
        M0_req = 1'b1; M1_req = 1'b1;
        M1_address = 8'h21; M1_wr = 1'b1; M1_dout = 8'h5A;
        cyc(0, 0);
        cyc(1, 0);                               // M0 wins first tie
        M0_req = 1'b0;
        cyc(1, 0);
        M0_req = 1'b1; M0_address = 8'h10;
        repeat (MAX_HOLD) cyc(0, 1);             // M1 held exactly MAX_HOLD
        repeat (MAX_HOLD) cyc(1, 0);             // then M0 for MAX_HOLD

        // M1 reads: slave 1 region, then unmapped region
        M1_address = 8'h20; M1_wr = 1'b0;
        cyc(0, 1);                               // S1_sel, M_din = 3C
        M1_address = 8'h80;
        cyc(0, 1);                               // no select, M_din = 00

        // Reset while GNT1 is active
        reset = 1'b1;
        cyc(0, 1);                               // sync reset: grant still up
        reset = 1'b0; M0_req = 1'b0; M1_req = 1'b0;
        cyc(0, 0);                               // all outputs back to zero
        M0_req = 1'b1; M1_req = 1'b1;
        M0_address = 8'h3F; M0_wr = 1'b1; M0_dout = 8'hC3;
        M1_address = 8'h02;
        cyc(0, 0);
        cyc(1, 0);                               // M0 first after reset

        // Alternating two-cycle tenures: M0, M1, M0, M1
        M0_req = 1'b0;
        cyc(1, 0);
        M0_req = 1'b1;
        cyc(0, 1);
        M1_req = 1'b0;
        cyc(0, 1);
        M1_req = 1'b1;
        cyc(1, 0);
        M0_req = 1'b0;
        cyc(1, 0);
        cyc(0, 1);
        M1_req = 1'b0;
        cyc(0, 1);
        cyc(0, 0);                               // IDLE drives zeros on bus
        cyc(0, 0);

        repeat (2) @(posedge clk);
        total = total + 1;
        if (sb_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire
